// File: rtl/mem_1rw_bytemask.sv
// Single-port synchronous RAM with a registered, read-first read port and
// byte-lane write enables; maps onto block RAM with byte-write support.
module mem_1rw_bytemask #(
    parameter int ELEMENTS_W = 10,
    parameter int WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ELEMENTS_W-1:0] address,
    input  logic                  read,
    output logic [WIDTH-1:0]      readdata,
    input  logic                  write,
    input  logic [WIDTH/8-1:0]    writeenable,
    input  logic [WIDTH-1:0]      writedata
);

    localparam int DEPTH = 1 << ELEMENTS_W;
    localparam int NB    = WIDTH / 8;

    // Storage is deliberately never reset so it can infer as block RAM.
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] readdata_q;
    logic [WIDTH-1:0] readdata_d;

    always_ff @(posedge clk) begin
        if (rst_n && write) begin
            for (int i = 0; i < NB; i++) begin
                if (writeenable[i]) begin
                    mem_q[address][8*i +: 8] <= writedata[8*i +: 8];
                end
            end
        end
    end

    // Holding the last result while read is low lets an AXI slave stall rdata.
    always_comb begin
        readdata_d = readdata_q;
        if (read) begin
            readdata_d = mem_q[address];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            readdata_q <= '0;
        end else begin
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;

`ifdef MEM_1RW_BYTEMASK_CHECKS
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!((read || write) && $isunknown(address)))
                else $error("mem_1rw_bytemask: X on address during access");
            assert (!(write && $isunknown(writeenable)))
                else $error("mem_1rw_bytemask: X on writeenable during write");
        end
    end
`endif

endmodule

// File: tb/tb_mem_1rw_bytemask.sv
// Directed bench for mem_1rw_bytemask: a 32-bit/1024-word instance driven from
// a vector table, and a 64-bit/16-word instance driven by a short sequence.
module tb_mem_1rw_bytemask;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        rst_n = 1'b0;
    logic [9:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [3:0]  writeenable = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;

    // 64-bit instance
    logic        rst_n2 = 1'b0;
    logic [3:0]  address2 = '0;
    logic        read2 = 1'b0;
    logic        write2 = 1'b0;
    logic [7:0]  writeenable2 = '0;
    logic [63:0] writedata2 = '0;
    logic [63:0] readdata2;

    int total = 0;
    int bad   = 0;

    mem_1rw_bytemask #(.ELEMENTS_W(10), .WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .address(address), .read(read),
        .readdata(readdata), .write(write), .writeenable(writeenable),
        .writedata(writedata)
    );

    mem_1rw_bytemask #(.ELEMENTS_W(4), .WIDTH(64)) dut64 (
        .clk(clk), .rst_n(rst_n2), .address(address2), .read(read2),
        .readdata(readdata2), .write(write2), .writeenable(writeenable2),
        .writedata(writedata2)
    );

    typedef struct {
        string       name;
        logic        rst_n;
        logic        rd;
        logic        wr;
        logic [9:0]  addr;
        logic [3:0]  we;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic r, input logic rd,
                       input logic wr, input logic [9:0] addr,
                       input logic [3:0] we, input logic [31:0] wd,
                       input logic [31:0] exp);
        vec_t v;
        v.name = name; v.rst_n = r; v.rd = rd; v.wr = wr; v.addr = addr;
        v.we = we; v.wd = wd; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic check32(input string name, input logic [31:0] exp);
        total++;
        if (readdata !== exp) begin
            bad++;
            $display("FAIL %s: readdata=%h expected=%h", name, readdata, exp);
        end
    endtask

    task automatic check64(input string name, input logic [63:0] exp);
        total++;
        if (readdata2 !== exp) begin
            bad++;
            $display("FAIL %s: readdata=%h expected=%h", name, readdata2, exp);
        end
    endtask

    task automatic step64(input logic rd, input logic wr, input logic [3:0] addr,
                          input logic [7:0] we, input logic [63:0] wd);
        @(negedge clk);
        rst_n2 = 1'b1; read2 = rd; write2 = wr; address2 = addr;
        writeenable2 = we; writedata2 = wd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //   name           rst rd wr addr   we       wd            expected readdata
        add("rst_read0",    0, 1, 0, 10'd5,  4'h0, 32'h0,        32'h0);
        add("rst_read1",    0, 1, 0, 10'd5,  4'h0, 32'h0,        32'h0);
        add("idle0",        1, 0, 0, 10'd5,  4'h0, 32'h0,        32'h0);
        add("idle1",        1, 0, 0, 10'd5,  4'h0, 32'h0,        32'h0);
        add("wr_full",      1, 0, 1, 10'd5,  4'hF, 32'hDEADBEEF, 32'h0);
        add("rd_full",      1, 1, 0, 10'd5,  4'h0, 32'h0,        32'hDEADBEEF);
        add("wr_mask0101",  1, 0, 1, 10'd5,  4'h5, 32'h11223344, 32'hDEADBEEF);
        add("rd_mask0101",  1, 1, 0, 10'd5,  4'h0, 32'h0,        32'hDE22BE44);
        add("wr_mask0000",  1, 0, 1, 10'd5,  4'h0, 32'hFFFFFFFF, 32'hDE22BE44);
        add("rd_mask0000",  1, 1, 0, 10'd5,  4'h0, 32'h0,        32'hDE22BE44);
        add("wr_addr7",     1, 0, 1, 10'd7,  4'hF, 32'hCAFEF00D, 32'hDE22BE44);
        add("wr_addr3",     1, 0, 1, 10'd3,  4'hF, 32'hAAAAAAAA, 32'hDE22BE44);
        add("rd_addr5",     1, 1, 0, 10'd5,  4'h0, 32'h0,        32'hDE22BE44);
        add("hold0",        1, 0, 0, 10'd7,  4'h0, 32'h0,        32'hDE22BE44);
        add("hold1",        1, 0, 0, 10'd7,  4'h0, 32'h0,        32'hDE22BE44);
        add("hold2_we_ign", 1, 0, 0, 10'd7,  4'hF, 32'h0,        32'hDE22BE44);
        add("rd_addr7",     1, 1, 0, 10'd7,  4'h0, 32'h0,        32'hCAFEF00D);
        add("rw_collide",   1, 1, 1, 10'd3,  4'hF, 32'h55555555, 32'hAAAAAAAA);
        add("rd_after_rw",  1, 1, 0, 10'd3,  4'h0, 32'h0,        32'h55555555);
        add("wr_addr0",     1, 0, 1, 10'd0,  4'hF, 32'h01234567, 32'h55555555);
        add("wr_addrmax",   1, 0, 1, 10'd1023, 4'hF, 32'h89ABCDEF, 32'h55555555);
        add("rd_addr0",     1, 1, 0, 10'd0,  4'h0, 32'h0,        32'h01234567);
        add("rd_addrmax",   1, 1, 0, 10'd1023, 4'h0, 32'h0,      32'h89ABCDEF);
        add("rst_blk_wr",   0, 1, 1, 10'd3,  4'hF, 32'h0,        32'h0);
        add("rd_after_rst", 1, 1, 0, 10'd3,  4'h0, 32'h0,        32'h55555555);
        add("rd_addr7_b",   1, 1, 0, 10'd7,  4'h0, 32'h0,        32'hCAFEF00D);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n; read = vecs[i].rd; write = vecs[i].wr;
            address = vecs[i].addr; writeenable = vecs[i].we;
            writedata = vecs[i].wd;
            @(posedge clk);
            #1;
            check32(vecs[i].name, vecs[i].exp);
        end

        // 64-bit instance has been held in reset with read=0 all along.
        check64("w64_reset", 64'h0);
        step64(0, 1, 4'd0,  8'hFF, 64'h0011223344556677);
        step64(0, 1, 4'd15, 8'hFF, 64'h8899AABBCCDDEEFF);
        step64(1, 0, 4'd0,  8'h00, 64'h0);
        check64("w64_rd_addr0", 64'h0011223344556677);
        step64(1, 0, 4'd15, 8'h00, 64'h0);
        check64("w64_rd_addr15", 64'h8899AABBCCDDEEFF);
        step64(0, 1, 4'd15, 8'b1010_0101, 64'h1111111111111111);
        check64("w64_hold", 64'h8899AABBCCDDEEFF);
        step64(1, 0, 4'd15, 8'h00, 64'h0);
        check64("w64_mask_a5", 64'h119911BBCC11EE11);
        step64(1, 1, 4'd0, 8'h0F, 64'hFFFFFFFFFFFFFFFF);
        check64("w64_rw_collide", 64'h0011223344556677);
        step64(1, 0, 4'd0,  8'h00, 64'h0);
        check64("w64_rd_after_rw", 64'h00112233FFFFFFFF);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_1rw_bytemask.md
Name: mem_1rw_bytemask

Overview:
- Single-port synchronous RAM: one shared address, registered read port, byte-masked write port.
- Backing store for on-chip memory peripherals such as the AXI BRAM slave.
- Maps directly onto FPGA block RAM.
- Read data appears one clock after the read request and holds until the next read.

Parameters:
- ELEMENTS_W, 10, log2 of word count; depth = 2**ELEMENTS_W words.
- WIDTH, 32, word width in bits; must be a multiple of 8 (32 or 64 in practice).

Ports:
- clk  in  1  clock; all activity on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- address  in  ELEMENTS_W  word index shared by read and write.
- read  in  1  read request; samples address this cycle.
- readdata  out  WIDTH  registered read result.
- write  in  1  write request.
- writeenable  in  WIDTH/8  byte lanes to write; bit i covers writedata[8i+7:8i].
- writedata  in  WIDTH  write data.

Behaviour:
- Storage is an array of 2**ELEMENTS_W words of WIDTH bits.
- Contents are not initialised and are not cleared by reset.
- Reset: while rst_n=0 at a clock edge, readdata is set to 0 and no read or write takes effect.
- Read:
  - If read=1 at edge N, readdata after edge N = mem[address sampled at N].
  - Latency is exactly 1 cycle.
- Read hold: if read=0, readdata keeps its previous value indefinitely. The AXI slave relies on this to stall rdata while rready=0.
- Write:
  - If write=1 at edge N, for each i with writeenable[i]=1, byte i of mem[address] takes byte i of writedata.
  - Bytes whose enable bit is 0 are unchanged.
  - write=1 with writeenable all zero changes nothing.
- Simultaneous read=1 and write=1 (same address by construction): read-first.
  - readdata gets the word as it was before the write.
  - The write still commits; a following read returns the new data.
- write=0: writeenable and writedata are ignored.
- Address range: every ELEMENTS_W-bit address is valid, so no out-of-range case exists. Range checking is the caller's job.
- Idle (read=0, write=0): no state changes.
- Fully synchronous; no combinational path from any input to readdata.
- Implementation:
  - Per-byte-lane write loop, inferable as BRAM with byte enables.
  - A register for readdata.
  - Optional simulation-only checks, compiled out by default: X on address when read or write is asserted; X on writeenable when write is asserted.

Test Plan:
- Reset then hold: rst_n=0 for 2 cycles with read=1 -> readdata=0. After release with read=0 and write=0 -> readdata stays 0.
- Full write/read: write addr 5 data 0xDEADBEEF, writeenable=4'b1111. Next cycle read addr 5 -> readdata=0xDEADBEEF on the following cycle.
- Byte mask: addr 5 holds 0xDEADBEEF. Write 0x11223344 with writeenable=4'b0101 -> read returns 0xDE22BE44. Then write with writeenable=0 -> value unchanged.
- Read hold: read addr 5, then read=0 for 3 cycles while address changes to 7 -> readdata stays at mem[5]. Then read addr 7 -> mem[7] after 1 cycle.
- Read-first collision: mem[3]=0xAAAAAAAA. Same cycle read=1, write=1, addr 3, data 0x55555555, all enables -> readdata=0xAAAAAAAA. Next read of addr 3 -> 0x55555555.
- Address extremes: write distinct values to addr 0 and addr 2**ELEMENTS_W-1 -> each reads back its own value with no aliasing. Repeat with WIDTH=64 and 8-lane masks.
